// File: rtl/fdma_wr_arbiter4_pkg.sv
// Shared types and the round-robin search helper for the FDMA write arbiter.
package fdma_wr_arbiter4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BUSY  = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } rr_pick_t;

  // First requesting channel found when searching ptr, ptr+1, ... (wrapping mod 4).
  function automatic rr_pick_t rr_next(input logic [3:0] req, input logic [1:0] ptr);
    rr_pick_t   r;
    logic [1:0] c;
    r = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      c = ptr + k[1:0];
      if (!r.found && req[c]) begin
        r.found = 1'b1;
        r.idx   = c;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fdma_wr_arbiter4_rr_pick4.sv
// Combinational round-robin picker over four request lines.
module rr_pick4
  import fdma_wr_arbiter4_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       found,
  output logic [1:0] idx
);

  rr_pick_t pick;

  // Search starts at ptr so the channel after the last winner has priority.
  always_comb begin
    pick  = rr_next(req, ptr);
    found = pick.found;
    idx   = pick.idx;
  end

endmodule

// File: rtl/fdma_wr_arbiter4.sv
// Four-to-one FDMA write-channel arbiter: round-robin burst grant, address/size
// latch and per-channel data/strobe steering toward a single FDMA write port.
module fdma_wr_arbiter4
  import fdma_wr_arbiter4_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 23
) (
  input  logic                      ui_clk,
  input  logic                      ui_rstn,

  input  logic [AXI_ADDR_WIDTH-1:0] fdma_waddr_1,
  input  logic                      fdma_wareq_1,
  input  logic [15:0]               fdma_wsize_1,
  output logic                      fdma_wbusy_1,
  input  logic [AXI_DATA_WIDTH-1:0] fdma_wdata_1,
  output logic                      fdma_wvalid_1,

  input  logic [AXI_ADDR_WIDTH-1:0] fdma_waddr_2,
  input  logic                      fdma_wareq_2,
  input  logic [15:0]               fdma_wsize_2,
  output logic                      fdma_wbusy_2,
  input  logic [AXI_DATA_WIDTH-1:0] fdma_wdata_2,
  output logic                      fdma_wvalid_2,

  input  logic [AXI_ADDR_WIDTH-1:0] fdma_waddr_3,
  input  logic                      fdma_wareq_3,
  input  logic [15:0]               fdma_wsize_3,
  output logic                      fdma_wbusy_3,
  input  logic [AXI_DATA_WIDTH-1:0] fdma_wdata_3,
  output logic                      fdma_wvalid_3,

  input  logic [AXI_ADDR_WIDTH-1:0] fdma_waddr_4,
  input  logic                      fdma_wareq_4,
  input  logic [15:0]               fdma_wsize_4,
  output logic                      fdma_wbusy_4,
  input  logic [AXI_DATA_WIDTH-1:0] fdma_wdata_4,
  output logic                      fdma_wvalid_4,

  output logic [AXI_ADDR_WIDTH-1:0] fdma_waddr,
  output logic                      fdma_wareq,
  output logic [15:0]               fdma_wsize,
  input  logic                      fdma_wbusy,
  output logic [AXI_DATA_WIDTH-1:0] fdma_wdata,
  input  logic                      fdma_wvalid,

  output logic [1:0]                grant_o,
  output logic                      active_o
);

  arb_state_t                state_q, state_d;
  logic [1:0]                ptr_q;
  logic [1:0]                grant_q;
  logic [AXI_ADDR_WIDTH-1:0] waddr_q;
  logic [15:0]               wsize_q;

  logic [3:0]                req_vec;
  logic                      pick_found;
  logic [1:0]                pick_idx;
  logic [AXI_ADDR_WIDTH-1:0] sel_addr;
  logic [15:0]               sel_size;
  logic                      active;
  logic [3:0]                own;

  assign req_vec = {fdma_wareq_4, fdma_wareq_3, fdma_wareq_2, fdma_wareq_1};

  rr_pick4 u_pick (
    .req   (req_vec),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Candidate address/size of the channel the picker currently favours.
  always_comb begin
    sel_addr = fdma_waddr_1;
    sel_size = fdma_wsize_1;
    case (pick_idx)
      2'd0: begin sel_addr = fdma_waddr_1; sel_size = fdma_wsize_1; end
      2'd1: begin sel_addr = fdma_waddr_2; sel_size = fdma_wsize_2; end
      2'd2: begin sel_addr = fdma_waddr_3; sel_size = fdma_wsize_3; end
      default: begin sel_addr = fdma_waddr_4; sel_size = fdma_wsize_4; end
    endcase
  end

  // Next-state logic: grant, wait for controller busy, wait for busy to drop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pick_found) state_d = ST_GRANT;
      ST_GRANT: if (fdma_wbusy) state_d = ST_BUSY;
      ST_BUSY:  if (!fdma_wbusy) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, winner latch and round-robin pointer registers.
  always_ff @(posedge ui_clk or negedge ui_rstn) begin
    if (!ui_rstn) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      waddr_q <= '0;
      wsize_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && pick_found) begin
        grant_q <= pick_idx;
        waddr_q <= sel_addr;
        wsize_q <= sel_size;
      end
      if (state_q == ST_BUSY && !fdma_wbusy) begin
        ptr_q <= grant_q + 2'd1;
      end
    end
  end

  assign active     = (state_q != ST_IDLE);
  assign active_o   = active;
  assign grant_o    = grant_q;
  assign fdma_wareq = (state_q == ST_GRANT);
  assign fdma_waddr = waddr_q;
  assign fdma_wsize = wsize_q;

  // One-hot ownership; all zero outside a grant so stray strobes reach no one.
  always_comb begin
    own = '0;
    if (active) own[grant_q] = 1'b1;
  end

  assign fdma_wvalid_1 = fdma_wvalid & own[0];
  assign fdma_wvalid_2 = fdma_wvalid & own[1];
  assign fdma_wvalid_3 = fdma_wvalid & own[2];
  assign fdma_wvalid_4 = fdma_wvalid & own[3];
  assign fdma_wbusy_1  = fdma_wbusy & own[0];
  assign fdma_wbusy_2  = fdma_wbusy & own[1];
  assign fdma_wbusy_3  = fdma_wbusy & own[2];
  assign fdma_wbusy_4  = fdma_wbusy & own[3];

  // Beat data from the granted channel; zero while no grant is held.
  always_comb begin
    fdma_wdata = '0;
    if (active) begin
      case (grant_q)
        2'd0:    fdma_wdata = fdma_wdata_1;
        2'd1:    fdma_wdata = fdma_wdata_2;
        2'd2:    fdma_wdata = fdma_wdata_3;
        default: fdma_wdata = fdma_wdata_4;
      endcase
    end
  end

endmodule

// File: doc/fdma_wr_arbiter4.md
# fdma_wr_arbiter4

Four-to-one FDMA write-channel arbiter between the four per-channel frame-buffer write engines of the four-channel splicer and the single FDMA write port of the SDRAM controller. It grants one write burst at a time in round-robin order, latches the winner's address and size, steers the shared burst's data and beat strobes to and from that channel, and releases the port when the burst finishes. It runs entirely in the FDMA clock domain.

## Interface
Parameters:
- AXI_DATA_WIDTH, 32, FDMA data width
- AXI_ADDR_WIDTH, 23, FDMA address width

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- ui_clk  in  1  FDMA clock; all logic rises on it
- ui_rstn  in  1  asynchronous active-low reset
- fdma_waddr_n, n=1..4  in  AXI_ADDR_WIDTH  burst start address from channel n
- fdma_wareq_n  in  1  burst request from channel n
- fdma_wsize_n  in  16  burst length in beats from channel n
- fdma_wbusy_n  out  1  busy returned to channel n
- fdma_wdata_n  in  AXI_DATA_WIDTH  beat data from channel n; valid in the same cycle as its wvalid
- fdma_wvalid_n  out  1  beat strobe returned to channel n
- fdma_waddr  out  AXI_ADDR_WIDTH  address to the controller
- fdma_wareq  out  1  request to the controller
- fdma_wsize  out  16  burst length to the controller
- fdma_wbusy  in  1  controller busy
- fdma_wdata  out  AXI_DATA_WIDTH  beat data to the controller
- fdma_wvalid  in  1  controller beat strobe
- grant_o  out  2  index of the granted channel (0..3 = channels 1..4)
- active_o  out  1  a grant is held (GRANT or BUSY)

## Operation
- The FSM has three states: IDLE, GRANT and BUSY.
- **IDLE**
  - Candidates are the channels whose wareq is high.
  - Starting search at ptr, the first candidate wins (ptr..3, then 0..ptr-1).
  - On a win: register grant_o, latch that channel's waddr and wsize, and go to GRANT.
  - With no candidate, stay in IDLE.
- **GRANT**
  - fdma_wareq=1 from the latched registers.
  - When fdma_wbusy is seen high: fdma_wareq=0 and go to BUSY.
  - The request is held even if the channel drops wareq_n; a latched request is never withdrawn.
- **BUSY**
  - When fdma_wbusy is seen low, go to IDLE.
  - In the same edge, set ptr = grant_o+1 (mod 4).
- **Steering**
  - fdma_wdata = fdma_wdata_{grant}, combinational on grant_o. It is meaningful only while active_o=1 and drives 0 otherwise.
  - fdma_wvalid_n = fdma_wvalid & active_o & (grant_o==n-1). Non-granted channels read 0.
  - fdma_wbusy_n = fdma_wbusy & active_o & (grant_o==n-1). Channels see busy only for their own burst, which they use to clear their own wareq.
- fdma_wvalid or fdma_wbusy arriving in IDLE is ignored. No channel sees it.
- Width rules: fdma_wsize passes through unmodified at 16 bits, including the value 0. The arbiter does not count beats; burst end is defined only by fdma_wbusy falling.

## Timing
- **Reset values:**
  - state IDLE, ptr 0
  - grant_o 0, active_o 0
  - fdma_wareq 0, fdma_waddr 0, fdma_wsize 0
  - fdma_wdata 0, all wbusy_n 0 and all wvalid_n 0
- **Reset mid-burst:** everything returns to reset values immediately. No burst is resumed.
- **Request latency:** wareq_n sampled high at edge t (IDLE) gives fdma_wareq=1 with valid addr/size after edge t, i.e. one cycle.
- **Busy handling:** fdma_wareq falls after the first edge at which fdma_wbusy=1.
- **Release:** the edge sampling fdma_wbusy=0 in BUSY returns to IDLE. The earliest next grant is one edge later, so there is one idle cycle between bursts.
- **Beat path:** wvalid and wdata steering is zero-latency combinational. The controller samples fdma_wdata in the cycle it asserts fdma_wvalid.
- **Simultaneous requests:** all four high with ptr=0 gives grants in order 1,2,3,4,1,...
- A channel re-requesting immediately after its own burst waits behind the other pending channels.

## Structure
- A shared package holds:
  - the FSM state encoding (IDLE/GRANT/BUSY)
  - the round-robin next-index function (4-bit request, 2-bit ptr → 2-bit winner + found flag)
- One natural sub-module is rr_pick4: a combinational round-robin picker, instanced once.
- The address/size latch, FSM and steering muxes live in the top module.

## Test plan
- **Single request:** reset, then wareq_2=1, waddr_2=0x000400, wsize_2=256.
  - Required: fdma_wareq=1 with addr 0x000400 and size 256 one cycle later; grant_o=1.
  - Model busy high for 256 beats with wvalid; only wvalid_2 pulses 256 times and fdma_wdata equals wdata_2.
- **All four requesting:** hold all four wareq high and complete each burst in 8 beats.
  - Required: grant sequence 0,1,2,3,0.
  - Exactly one idle cycle between busy falling and the next fdma_wareq rising.
- **Withdrawn request:** channel 3 drops wareq_3 while in GRANT.
  - Required: fdma_wareq stays 1 until busy rises; addr and size stay unchanged.
- **Stray strobes in IDLE:** pulse fdma_wvalid and fdma_wbusy while in IDLE.
  - Required: every wvalid_n and wbusy_n stays 0 and the state stays IDLE.
- **Reset mid-burst:** assert ui_rstn low during beat 100 of a 256-beat burst on channel 4.
  - Required: all outputs go to 0 immediately and ptr=0.
  - After release, channel 1 wins when channels 1 and 4 request together.
- **Back-to-back re-request:** channel 1 re-requests immediately after its own burst while channel 2 is pending.
  - Required: channel 2 is granted before channel 1.
